ex_muldiv: RTL and testbench

- Parametrised multiply/divide execute unit. It sits beside the single-cycle ALU in the EX stage and owns the architectural HI/LO registers.
- Executes MULT/MULTU, which are pipelined with configurable latency, and DIV/DIVU, which are iterative at one quotient bit per cycle. It also executes MTHI/MTLO.
- Uses a valid/ready request handshake, a one-cycle done pulse, and a flush for pipeline squash.

---
 rtl/ex_muldiv_if.sv | 28 ++
 rtl/ex_muldiv.sv | 234 +++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// master: the pipeline side (drives request, flush); slave: ex_muldiv.
// Signals: req_valid/req_ready handshake, op/a/b operands, flush, busy/done status, hi/lo results.
`timescale 1ns/1ps
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req_valid, op, a, b, flush,
    input  req_ready, busy, done, hi, lo
  );

  modport slave (
    input  req_valid, op, a, b, flush,
    output req_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/ex_muldiv.sv
// Multiply/divide execute unit owning HI/LO: MULT/MULTU, DIV/DIVU, MTHI/MTLO.
// Latency: MUL_LATENCY cycles for multiply, WIDTH+1 for divide, done the cycle after accept for MTHI/MTLO.
// Backpressure: req_ready is low while an op is in flight or flush is asserted; flush squashes without update.
// Ports: clock_i, reset_i (sync, active-high), bus (ex_muldiv_if.slave: req_valid/req_ready, op, a, b,
//        flush in; busy, done pulse, hi, lo out).
`timescale 1ns/1ps
module ex_muldiv #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic       clock_i,
  input  logic       reset_i,
  ex_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e state_q, state_d;

  logic             ready;
  logic             accept;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder magnitude
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0]   dvd_q, dvd_d;     // original dividend, returned as HI on divide-by-zero
  logic               negq_q, negq_d;   // quotient must be negated in FIX
  logic               negr_q, negr_d;   // remainder must be negated in FIX
  logic               dz_q, dz_d;       // divisor was zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand conditioning and per-cycle arithmetic
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               mul_signed;
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_p;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign ready  = (state_q == S_IDLE) && !bus.flush;
  assign accept = bus.req_valid && ready;

  always_comb begin
    a_neg      = (bus.op == OP_DIV) && bus.a[WIDTH-1];
    b_neg      = (bus.op == OP_DIV) && bus.b[WIDTH-1];
    a_mag      = a_neg ? -bus.a : bus.a;
    b_mag      = b_neg ? -bus.b : bus.b;
    mul_signed = (bus.op == OP_MULT);
    // A 2W x 2W multiply truncated to 2W bits yields the exact signed or
    // unsigned product once the operands are extended accordingly.
    mul_a      = {{WIDTH{mul_signed & bus.a[WIDTH-1]}}, bus.a};
    mul_b      = {{WIDTH{mul_signed & bus.b[WIDTH-1]}}, bus.b};
    mul_p      = mul_a * mul_b;
    // Restoring step: one extra bit because the shifted remainder can reach 2*divisor-1.
    rem_shift  = {rem_q, quo_q[WIDTH-1]};
    rem_diff   = rem_shift - {1'b0, dvs_q};
    quo_fix    = negq_q ? -quo_q : quo_q;
    rem_fix    = negr_q ? -rem_q : rem_q;
  end

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.op == OP_MULT || bus.op == OP_MULTU) begin
            state_d = S_MUL;
          end else if (bus.op == OP_DIV || bus.op == OP_DIVU) begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (bus.flush || cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req_ready = ready;
    bus.busy      = (state_q != S_IDLE);
    bus.done      = done_q;
    bus.hi        = hi_q;
    bus.lo        = lo_q;
  end

  // Datapath next-state
  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    dvd_d  = dvd_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              // Product is registered at accept; the counter models the
              // remaining MUL_LATENCY-1 stages.
              prod_d = mul_p;
              cnt_d  = CW'(MUL_LATENCY - 1);
            end
            OP_DIV, OP_DIVU: begin
              quo_d  = a_mag;
              rem_d  = '0;
              dvs_d  = b_mag;
              dvd_d  = bus.a;
              negq_d = a_neg ^ b_neg;
              negr_d = a_neg;
              dz_d   = (bus.b == '0);
              cnt_d  = CW'(WIDTH);
            end
            OP_MTHI: begin
              hi_d   = bus.a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.a;
              done_d = 1'b1;
            end
            default: ;  // reserved: swallowed with no effect
          endcase
        end
      end
      S_MUL: begin
        if (!bus.flush) begin
          if (cnt_q == '0) begin
            {hi_d, lo_d} = prod_q;
            done_d       = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_DIV: begin
        if (!bus.flush) begin
          quo_d = {quo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
          rem_d = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        if (!bus.flush) begin
          if (dz_q) begin
            // Divide-by-zero: the iteration already gives an all-ones
            // quotient, but sign fixup would disturb it, so override.
            lo_d = '1;
            hi_d = dvd_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      prod_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      dvd_q  <= dvd_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
`timescale 1ns/1ps
module tb_ex_muldiv;

  localparam int W       = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = W + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_lat;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ex_muldiv_if #(.WIDTH(W)) bus ();

  ex_muldiv #(.WIDTH(W), .MUL_LATENCY(MUL_LAT)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int           n_vec = 0;
  int           n_bad = 0;
  logic [2*W-1:0] sb[$];
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  vec_t         vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference using native SV arithmetic.
  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb2;
    logic [63:0] ua, ub;
    int          ia, ib, q, r;
    model = '0;
    case (op)
      OP_MULT: begin
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        model = 64'(sa * sb2);
      end
      OP_MULTU: begin
        ua = {32'd0, a};
        ub = {32'd0, b};
        model = ua * ub;
      end
      OP_DIV: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else begin
          ia = $signed(a);
          ib = $signed(b);
          q = ia / ib;
          r = ia % ib;
          model = {32'(r), 32'(q)};
        end
      end
      OP_DIVU: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input int exp_lat);
    int lat;
    int bsy;
    logic [2*W-1:0] e;
    check("ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clock);
    sb.push_back({exp_hi, exp_lo});
    #1;
    bus.req_valid = 1'b0;
    bus.a = ~a;          // operands must have been captured
    bus.b = b ^ 32'h5A5A_5A5A;
    bus.op = OP_MTHI;
    lat = 0;
    bsy = 0;
    @(negedge clock);
    while (!bus.done && lat < 100) begin
      if (bus.busy) bsy++;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    if (!bus.done) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required %0d", lat, exp_lat);
    end else if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_empty: got done with no expected entry, required none");
    end else begin
      e = sb.pop_front();
      check("hi", bus.hi, e[2*W-1:W]);
      check("lo", bus.lo, e[W-1:0]);
      model_hi = e[2*W-1:W];
      model_lo = e[W-1:0];
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", bsy, exp_lat);
  endtask

  task automatic watch_no_done(input int n, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.done) seen++;
    end
    check(name, seen, 0);
  endtask

  task automatic start_div_at(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid = 1'b1;
    bus.op = OP_DIV;
    bus.a = a;
    bus.b = b;
    @(posedge clock);                // cycle 0
    #1 bus.req_valid = 1'b0;
    repeat (9) @(posedge clock);     // cycles 1..9
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] rexp;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    vecs[3]  = '{OP_DIVU,  32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF, DIV_LAT};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
    vecs[5]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};
    vecs[6]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, DIV_LAT};
    vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT};
    vecs[8]  = '{OP_DIV,   32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, DIV_LAT};
    vecs[9]  = '{OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, DIV_LAT};
    vecs[10] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_LAT};

    bus.req_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ready", bus.req_ready, 1);
    reset = 1'b0;

    // Table: consecutive entries are issued in the cycle done is high
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_lat);
    end

    // Randomised mul/div against the native-arithmetic model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2) != 0 ? 32'($urandom) : 32'($urandom_range(1, 50)));
      rexp = model(rop, ra, rb);
      run_op(rop, ra, rb, rexp[2*W-1:W], rexp[W-1:0], (rop < 2) ? MUL_LAT : DIV_LAT);
    end

    // MTHI then MTLO back-to-back
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.op = OP_MTHI;
    bus.a = 32'h1234_5678;
    @(posedge clock);
    @(negedge clock);
    check("mthi_done", bus.done, 1);
    check("mthi_hi", bus.hi, 32'h1234_5678);
    check("mthi_lo_kept", bus.lo, model_lo);
    check("mthi_ready", bus.req_ready, 1);
    check("mthi_busy", bus.busy, 0);
    bus.op = OP_MTLO;
    bus.a = 32'h9ABC_DEF0;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("mtlo_done", bus.done, 1);
    check("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", bus.hi, 32'h1234_5678);
    check("mtlo_ready", bus.req_ready, 1);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;
    @(negedge clock);
    check("mt_done_one_cycle", bus.done, 0);

    // Reserved op: accepted, no effect
    bus.req_valid = 1'b1;
    bus.op = 3'd6;
    bus.a = 32'h5555_5555;
    check("rsvd_ready", bus.req_ready, 1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    watch_no_done(4, "rsvd_no_done");
    check("rsvd_busy", bus.busy, 0);
    check("rsvd_hi", bus.hi, model_hi);
    check("rsvd_lo", bus.lo, model_lo);

    // flush with req_valid in IDLE: nothing accepted
    bus.req_valid = 1'b1;
    bus.op = OP_MTHI;
    bus.a = 32'hDEAD_BEEF;
    bus.flush = 1'b1;
    #1 check("flush_idle_ready", bus.req_ready, 0);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush_idle_done", bus.done, 0);
    check("flush_idle_hi", bus.hi, model_hi);

    // Flush DIV at cycle 10
    start_div_at(32'd1000, 32'd7);
    check("div_busy_c9", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_done", bus.done, 0);
    check("flush_hi", bus.hi, model_hi);
    check("flush_lo", bus.lo, model_lo);
    watch_no_done(40, "flush_no_late_done");
    run_op(OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, MUL_LAT);

    // Flush on the edge that would raise done
    run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, MUL_LAT);
    bus.req_valid = 1'b1;
    bus.op = OP_MULT;
    bus.a = 32'd7;
    bus.b = 32'd7;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b0;
    check("flush_last_done", bus.done, 0);
    check("flush_last_busy", bus.busy, 0);
    check("flush_last_hi", bus.hi, 32'd0);
    check("flush_last_lo", bus.lo, 32'd6);
    watch_no_done(5, "flush_last_no_done");

    // Reset DIV at cycle 10
    run_op(OP_MULTU, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_0000, MUL_LAT);
    start_div_at(32'd1000, 32'd7);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst10_hi", bus.hi, 0);
    check("rst10_lo", bus.lo, 0);
    check("rst10_ready", bus.req_ready, 1);
    check("rst10_busy", bus.busy, 0);
    check("rst10_done", bus.done, 0);
    model_hi = '0;
    model_lo = '0;
    watch_no_done(40, "rst10_no_done");
    run_op(OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, DIV_LAT);

    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
